// File: rtl/registro_universal_n.sv
// Universal WIDTH-bit register: hold / shift right / shift left / load, with a
// saturating shift counter. Define ROTATE_EN to recirculate shifted-out bits.
module registro_universal_n #(
  parameter  int WIDTH = 4,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_r,
  input  logic             sin_l,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_n,
  output logic             sout_r,
  output logic             sout_l,
  output logic             drained
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_SHR   = 2'b01;
  localparam logic [1:0] MODE_SHL   = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;

  logic [WIDTH-1:0] reg_q, reg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fill_r, fill_l;
  logic [CNT_W-1:0] cnt_inc;

`ifdef ROTATE_EN
  assign fill_r = reg_q[0];
  assign fill_l = reg_q[WIDTH-1];
`else
  assign fill_r = sin_r;
  assign fill_l = sin_l;
`endif

  // Saturate at WIDTH so repeated shifts keep drained asserted.
  assign cnt_inc = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 1'b1;

  always_comb begin
    reg_d = reg_q;
    cnt_d = cnt_q;
    if (!en) begin
      case (mode)
        MODE_SHR: begin
          reg_d = {fill_r, reg_q[WIDTH-1:1]};
          cnt_d = cnt_inc;
        end
        MODE_SHL: begin
          reg_d = {reg_q[WIDTH-2:0], fill_l};
          cnt_d = cnt_inc;
        end
        MODE_LOAD: begin
          reg_d = d;
          cnt_d = '0;
        end
        default: begin
          reg_d = reg_q;
          cnt_d = cnt_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_q <= '0;
      cnt_q <= CNT_MAX;
    end else begin
      reg_q <= reg_d;
      cnt_q <= cnt_d;
    end
  end

  assign q       = reg_q;
  assign q_n     = ~reg_q;
  assign sout_r  = reg_q[0];
  assign sout_l  = reg_q[WIDTH-1];
  assign drained = (cnt_q == CNT_MAX);

endmodule

// File: tb/tb_registro_universal_n.sv
// Self-checking bench for registro_universal_n: directed cases with literal
// expectations plus randomized traffic compared against a behavioural model.
module tb_registro_universal_n;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b1;
  logic [1:0]   mode = 2'b00;
  logic [W-1:0] d = '0;
  logic         sin_r = 1'b0;
  logic         sin_l = 1'b0;
  logic [W-1:0] q, q_n;
  logic         sout_r, sout_l, drained;

  int n_checks = 0;
  int n_errors = 0;

  registro_universal_n #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .d(d),
    .sin_r(sin_r), .sin_l(sin_l), .q(q), .q_n(q_n),
    .sout_r(sout_r), .sout_l(sout_l), .drained(drained)
  );

  always #5 clk = ~clk;

  // Behavioural model: contents as an integer, shifts as arithmetic.
  int m_q   = 0;
  int m_cnt = W;
  localparam int MASK = (1 << W) - 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q   = 0;
      m_cnt = W;
    end else if (!en && mode != 2'b00) begin
      if (mode == 2'b11) begin
        m_q   = int'(d);
        m_cnt = 0;
      end else begin
`ifdef ROTATE_EN
        if (mode == 2'b01) m_q = (m_q >> 1) | ((m_q & 1) << (W - 1));
        else               m_q = ((m_q << 1) | (m_q >> (W - 1))) & MASK;
`else
        if (mode == 2'b01) m_q = (m_q >> 1) | (int'(sin_r) << (W - 1));
        else               m_q = ((m_q << 1) | int'(sin_l)) & MASK;
`endif
        if (m_cnt < W) m_cnt = m_cnt + 1;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("model_q", int'(q), m_q);
    chk("model_q_n", int'(q_n), (~m_q) & MASK);
    chk("model_sout_r", int'(sout_r), m_q & 1);
    chk("model_sout_l", int'(sout_l), (m_q >> (W - 1)) & 1);
    chk("model_drained", int'(drained), (m_cnt == W) ? 1 : 0);
  end

  // Drive one operation mid-cycle, then settle just after the sampling edge.
  task automatic op(input logic e, input logic [1:0] m, input logic [W-1:0] dv,
                    input logic sr, input logic sl);
    @(negedge clk);
    #1;
    en = e; mode = m; d = dv; sin_r = sr; sin_l = sl;
    @(posedge clk);
    #1;
  endtask

  logic [3:0] exp_r [4];
  logic       exp_so [4];

  initial begin
    #12;
    rst_n = 1'b1;
    chk("reset_q", int'(q), 0);
    chk("reset_drained", int'(drained), 1);

    // Asynchronous reset mid-cycle
    op(1'b0, 2'b11, 4'hA, 1'b0, 1'b0);
    chk("preload_A", int'(q), 'hA);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_q", int'(q), 0);
    chk("async_rst_q_n", int'(q_n), 'hF);
    chk("async_rst_drained", int'(drained), 1);
    chk("async_rst_souts", int'({sout_l, sout_r}), 0);
    @(negedge clk);
    #3;
    rst_n = 1'b1;

    // Load, then en high blocks shifting
    op(1'b0, 2'b11, 4'h9, 1'b0, 1'b0);
    chk("load_9", int'(q), 9);
    chk("load_9_drained", int'(drained), 0);
    for (int i = 0; i < 3; i++) begin
      op(1'b1, 2'b01, 4'h0, 1'b1, 1'b1);
      chk("en_hold", int'(q), 9);
    end
    op(1'b0, 2'b00, 4'h3, 1'b1, 1'b1);
    chk("mode_hold", int'(q), 9);

`ifndef ROTATE_EN
    // Shift right drain
    exp_r  = '{4'h5, 4'h2, 4'h1, 4'h0};
    exp_so = '{1'b1, 1'b1, 1'b0, 1'b1};
    op(1'b0, 2'b11, 4'hB, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("shr_sout_r", int'(sout_r), int'(exp_so[i]));
      chk("shr_drained_pre", int'(drained), 0);
      op(1'b0, 2'b01, 4'h0, 1'b0, 1'b0);
      chk("shr_q", int'(q), int'(exp_r[i]));
    end
    chk("shr_drained", int'(drained), 1);
    op(1'b0, 2'b01, 4'h0, 1'b0, 1'b0);
    chk("shr_saturate", int'(drained), 1);

    // Shift left with serial input
    exp_r = '{4'h1, 4'h2, 4'h5, 4'hB};
    exp_so = '{1'b1, 1'b0, 1'b1, 1'b1};
    op(1'b0, 2'b11, 4'h0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      op(1'b0, 2'b10, 4'h0, 1'b0, exp_so[i]);
      chk("shl_q", int'(q), int'(exp_r[i]));
    end
    chk("shl_drained", int'(drained), 1);
`else
    // Rotation restores the pattern after WIDTH steps
    exp_r = '{4'h4, 4'h2, 4'h1, 4'h8};
    op(1'b0, 2'b11, 4'h8, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      op(1'b0, 2'b01, 4'h0, 1'b1, 1'b1);
      chk("rot_q", int'(q), int'(exp_r[i]));
    end
    chk("rot_drained", int'(drained), 1);
`endif

    // Mixed direction
    op(1'b0, 2'b11, 4'h6, 1'b0, 1'b0);
    op(1'b0, 2'b10, 4'h0, 1'b0, 1'b0);
    chk("mix_shl", int'(q), 'hC);
    op(1'b0, 2'b01, 4'h0, 1'b0, 1'b0);
    chk("mix_shr", int'(q), 6);
    chk("mix_drained", int'(drained), 0);

    // Randomized traffic, checked by the negedge compare process
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #4;
        rst_n = 1'b1;
      end
      op(($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)), 4'($urandom),
         1'($urandom), 1'($urandom));
    end

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
